data_bus: RTL and testbench
===========================

# data_bus

Data-side memory system for the single-cycle RV32 core: consumes the core's word-addressed load/store port, decodes it into a byte-maskable RAM region and an MMIO region, and answers loads combinationally in the same cycle. The MMIO region holds a 64-bit machine timer with compare interrupt and a console transmit FIFO drained over a valid/ready byte stream. It is the only consumer of the core's data port.

## Interface
- `RAM_WORDS`, 1024: RAM depth in 32-bit words; power of two, ≥ 16.
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, ≥ 2.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_mem_addr`  in  30  word address (byte address [31:2]).
- `i_mem_data`  in  32  store data, already lane-aligned.
- `i_mem_we`  in  1  store strobe for this cycle.
- `i_mem_mask`  in  4  byte-lane enables; bit n covers data[8n+7:8n].
- `o_mem_data`  out  32  load data, combinational from `i_mem_addr`.
- `o_tx_data`  out  8  byte at FIFO head.
- `o_tx_valid`  out  1  FIFO non-empty.
- `i_tx_ready`  in  1  sink accepts byte when high with `o_tx_valid`.
- `o_timer_irq`  out  1  registered `mtime >= mtimecmp`.

## Operation
- Decode on `i_mem_addr[29:28]`: 00 RAM (index = low log2(RAM_WORDS) bits, higher bits alias); 01 MMIO (word offset `i_mem_addr[3:0]`, rest ignored); 1x unmapped (reads 0, writes ignored).
- RAM: writes only lanes with mask bit set; no reset, contents survive `rst_n`.
- MMIO map (byte offset from 0x4000_0000):
  - 0x00 MTIME_LO, 0x04 MTIME_HI: RW, byte-maskable.
  - 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI: RW, byte-maskable.
  - 0x10 TX_DATA: write with mask[0]=1 pushes data[7:0]; reads 0, no side effect.
  - 0x14 TX_STATUS: read {.., cnt[8:3 width], ovf[2], empty[1], full[0]}; count field at bits [15:8], zero-extended; writing 1 to bit 2 (mask[0]) clears ovf; other bits RO.
  - other offsets: read 0, writes ignored.
- mtime: +1 every cycle (64-bit, wraps to 0). A write to MTIME_LO/HI replaces written bytes and suppresses that cycle's increment (both halves).
- Interrupt: `o_timer_irq` <= (mtime >= mtimecmp), unsigned 64-bit, using pre-edge values.
- FIFO: push when write to TX_DATA and (not full or pop same cycle); push when full without pop is dropped and sets sticky ovf. Pop when `o_tx_valid && i_tx_ready`. Simultaneous push+pop: count unchanged, order preserved. Pop when empty: impossible (valid low).
- Reset values: mtime 0, mtimecmp all ones, FIFO empty, ovf 0, `o_timer_irq` 0, `o_tx_valid` 0, `o_tx_data` 0 (head storage cleared), TX_STATUS reads 0x0000_0002.
- Reset asserted mid-operation clears all above immediately (async); pending FIFO bytes are lost; RAM untouched.

## Timing
- Loads: zero latency, `o_mem_data` valid same cycle as `i_mem_addr`.
- Stores: take effect at the rising edge ending the cycle; visible to loads next cycle.
- FIFO push in cycle N: `o_tx_valid` high from N+1; `o_tx_data` stable while valid and not popped.
- Interrupt: rises one cycle after mtime reaches mtimecmp; falls one cycle after mtimecmp write raises it above mtime.
- Reading MTIME_LO then MTIME_HI sees values one cycle apart; software handles carry.

## Configuration
- `DATA_BUS_TIMER_EN` defined: timer registers and `o_timer_irq` implemented as above.
- Undefined: no timer flops; offsets 0x00-0x0C read 0, writes ignored, `o_timer_irq` tied 0.

## Test plan
- Write 0xDEADBEEF to RAM word 5 mask 1111, then 0x000000AA mask 0001 -> read word 5 = 0xDEADBEAA next cycle; word 5+RAM_WORDS reads same.
- After reset, read TX_STATUS -> 0x0000_0002; read mtime at cycle 10 after reset release -> 10.
- Push 9 bytes 0x01..0x09 with `i_tx_ready`=0, DEPTH 8 -> full=1, ovf=1, count 8; raise ready -> 0x01..0x08 emitted one per cycle, then valid low; write 0x4 to TX_STATUS -> ovf 0.
- FIFO full, push 0x55 in same cycle as pop -> count stays 8, 0x55 emerges last.
- Write MTIMECMP = 100, MTIME = 95 -> `o_timer_irq` rises exactly when mtime = 101 is visible (one cycle after 100); write MTIMECMP_HI = 1 -> irq drops next cycle.
- Assert `rst_n` low with 3 bytes queued and irq high -> valid, irq drop immediately; RAM contents preserved.

Source files
------------

// File: rtl/data_bus.sv
// data_bus -- data-side memory system for the single-cycle RV32 core.
//
// Decodes the core's word-addressed load/store port into a byte-maskable
// RAM region and an MMIO region. Loads are answered combinationally in the
// same cycle. Stores land on the rising edge that ends the cycle.
//
// Address map (word address i_mem_addr[29:28]):
//   00 : RAM, indexed by the low log2(RAM_WORDS) bits (higher bits alias)
//   01 : MMIO, word offset i_mem_addr[3:0]
//   1x : unmapped, reads 0, writes ignored
//
// MMIO byte offsets from 0x4000_0000:
//   0x00 MTIME_LO    0x04 MTIME_HI       (RW, byte-maskable)
//   0x08 MTIMECMP_LO 0x0C MTIMECMP_HI    (RW, byte-maskable)
//   0x10 TX_DATA     write mask[0] pushes data[7:0], reads 0
//   0x14 TX_STATUS   {16'h0, count[15:8], 5'h0, ovf, empty, full}
//                    writing 1 to bit 2 (mask[0]) clears ovf
//
// Build option: define DATA_BUS_TIMER_EN to implement the 64-bit machine
// timer and o_timer_irq. Without it, offsets 0x00-0x0C read 0, writes to
// them are ignored and o_timer_irq is tied low.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_mem_addr   word address of the access
//   i_mem_data   store data, already lane-aligned
//   i_mem_we     store strobe
//   i_mem_mask   byte-lane enables for stores
//   o_mem_data   load data (combinational)
//   o_tx_data    byte at the TX FIFO head
//   o_tx_valid   TX FIFO non-empty
//   i_tx_ready   sink accepts the head byte
//   o_timer_irq  registered mtime >= mtimecmp

module data_bus #(
    parameter int RAM_WORDS  = 1024,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [29:0] i_mem_addr,
    input  logic [31:0] i_mem_data,
    input  logic        i_mem_we,
    input  logic [3:0]  i_mem_mask,
    output logic [31:0] o_mem_data,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_timer_irq
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [3:0] OFF_MTIME_LO    = 4'd0;
    localparam logic [3:0] OFF_MTIME_HI    = 4'd1;
    localparam logic [3:0] OFF_MTIMECMP_LO = 4'd2;
    localparam logic [3:0] OFF_MTIMECMP_HI = 4'd3;
    localparam logic [3:0] OFF_TX_DATA     = 4'd4;
    localparam logic [3:0] OFF_TX_STATUS   = 4'd5;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic          sel_ram;
    logic          sel_mmio;
    logic [3:0]    mmio_off;
    logic [AW-1:0] ram_idx;
    logic          ram_we;
    logic          mmio_we;
    logic          unused_addr_bits;

    assign sel_ram  = (i_mem_addr[29:28] == 2'b00);
    assign sel_mmio = (i_mem_addr[29:28] == 2'b01);
    assign mmio_off = i_mem_addr[3:0];
    assign ram_idx  = i_mem_addr[AW-1:0];
    assign ram_we   = i_mem_we && sel_ram;
    assign mmio_we  = i_mem_we && sel_mmio;

    // Aliased RAM bits and the ignored MMIO bits are deliberately unused.
    assign unused_addr_bits = ^i_mem_addr[27:0];

    // ------------------------------------------------------------------
    // RAM: no reset, contents survive rst_n
    // ------------------------------------------------------------------
    logic [31:0] ram_q [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_mem_mask[b]) begin
                    ram_q[ram_idx][8*b +: 8] <= i_mem_data[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          status_we;

    assign fifo_full  = (cnt_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (cnt_q == '0);
    assign pop        = !fifo_empty && i_tx_ready;
    assign push_req   = mmio_we && (mmio_off == OFF_TX_DATA) && i_mem_mask[0];
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push       = push_req && (!fifo_full || pop);
    assign status_we  = mmio_we && (mmio_off == OFF_TX_STATUS);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        if (push_req && !push) begin
            ovf_d = 1'b1;
        end else if (status_we && i_mem_mask[0] && i_mem_data[2]) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is cleared on reset so the head byte reads 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else if (push) begin
            fifo_q[wr_ptr_q] <= i_mem_data[7:0];
        end
    end

    assign o_tx_data  = fifo_q[rd_ptr_q];
    assign o_tx_valid = !fifo_empty;

    // ------------------------------------------------------------------
    // Machine timer
    // ------------------------------------------------------------------
    logic [31:0] timer_rd;

`ifdef DATA_BUS_TIMER_EN
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        irq_q, irq_d;
    logic [31:0] wmask;

    assign wmask = {{8{i_mem_mask[3]}}, {8{i_mem_mask[2]}},
                    {8{i_mem_mask[1]}}, {8{i_mem_mask[0]}}};

    // Any write to either mtime half replaces the written bytes and holds
    // the other half, so software can load a value without a carry race.
    always_comb begin
        mtime_d    = mtime_q + 64'd1;
        mtimecmp_d = mtimecmp_q;
        if (mmio_we) begin
            case (mmio_off)
                OFF_MTIME_LO:
                    mtime_d = {mtime_q[63:32],
                               (mtime_q[31:0] & ~wmask) | (i_mem_data & wmask)};
                OFF_MTIME_HI:
                    mtime_d = {(mtime_q[63:32] & ~wmask) | (i_mem_data & wmask),
                               mtime_q[31:0]};
                OFF_MTIMECMP_LO:
                    mtimecmp_d = {mtimecmp_q[63:32],
                                  (mtimecmp_q[31:0] & ~wmask) | (i_mem_data & wmask)};
                OFF_MTIMECMP_HI:
                    mtimecmp_d = {(mtimecmp_q[63:32] & ~wmask) | (i_mem_data & wmask),
                                  mtimecmp_q[31:0]};
                default: ;
            endcase
        end
        irq_d = (mtime_q >= mtimecmp_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            irq_q      <= irq_d;
        end
    end

    always_comb begin
        case (mmio_off[1:0])
            2'd0:    timer_rd = mtime_q[31:0];
            2'd1:    timer_rd = mtime_q[63:32];
            2'd2:    timer_rd = mtimecmp_q[31:0];
            default: timer_rd = mtimecmp_q[63:32];
        endcase
    end

    assign o_timer_irq = irq_q;
`else
    assign timer_rd    = '0;
    assign o_timer_irq = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Load data mux
    // ------------------------------------------------------------------
    logic [31:0] rd_data;
    logic [7:0]  cnt_byte;

    assign cnt_byte = 8'(cnt_q);

    always_comb begin
        rd_data = '0;
        if (sel_ram) begin
            rd_data = ram_q[ram_idx];
        end else if (sel_mmio) begin
            case (mmio_off)
                OFF_MTIME_LO, OFF_MTIME_HI, OFF_MTIMECMP_LO, OFF_MTIMECMP_HI:
                    rd_data = timer_rd;
                OFF_TX_STATUS:
                    rd_data = {16'h0, cnt_byte, 5'h0, ovf_q, fifo_empty, fifo_full};
                default:
                    rd_data = '0;
            endcase
        end
    end

    assign o_mem_data = rd_data;

endmodule

// File: tb/tb_data_bus.sv
module tb_data_bus;

    localparam int RAM_WORDS  = 1024;
    localparam int FIFO_DEPTH = 8;
    localparam logic [29:0] MMIO       = 30'h1000_0000;
    localparam logic [29:0] A_MT_LO    = MMIO | 30'd0;
    localparam logic [29:0] A_MT_HI    = MMIO | 30'd1;
    localparam logic [29:0] A_CMP_LO   = MMIO | 30'd2;
    localparam logic [29:0] A_CMP_HI   = MMIO | 30'd3;
    localparam logic [29:0] A_TX_DATA  = MMIO | 30'd4;
    localparam logic [29:0] A_TX_STAT  = MMIO | 30'd5;

`ifdef DATA_BUS_TIMER_EN
    localparam bit TIMER_EN = 1'b1;
`else
    localparam bit TIMER_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [29:0] i_mem_addr = '0;
    logic [31:0] i_mem_data = '0;
    logic        i_mem_we = 1'b0;
    logic [3:0]  i_mem_mask = '0;
    logic [31:0] o_mem_data;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready = 1'b0;
    logic        o_timer_irq;

    int tests_run = 0;
    int tests_failed = 0;

    // Scoreboards: expected load data and expected TX byte stream.
    logic [31:0] rd_exp_q[$];
    logic [7:0]  tx_exp_q[$];
    int          model_cnt = 0;
    bit          model_ovf = 1'b0;

    data_bus #(.RAM_WORDS(RAM_WORDS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_mem_addr (i_mem_addr),
        .i_mem_data (i_mem_data),
        .i_mem_we   (i_mem_we),
        .i_mem_mask (i_mem_mask),
        .o_mem_data (o_mem_data),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .i_tx_ready (i_tx_ready),
        .o_timer_irq(o_timer_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] status_word(int cnt, bit ovf);
        return {16'h0, 8'(cnt), 5'h0, ovf, (cnt == 0), (cnt == FIFO_DEPTH)};
    endfunction

    // Drives one store for one cycle; starts and ends just after a negedge.
    task automatic bus_write(input logic [29:0] a, input logic [31:0] d, input logic [3:0] m);
        i_mem_addr = a;
        i_mem_data = d;
        i_mem_mask = m;
        i_mem_we   = 1'b1;
        @(negedge clk);
        i_mem_we   = 1'b0;
        i_mem_mask = 4'h0;
    endtask

    task automatic bus_read(input logic [29:0] a, output logic [31:0] d);
        i_mem_addr = a;
        i_mem_we   = 1'b0;
        #1;
        d = o_mem_data;
    endtask

    task automatic fifo_push(input logic [7:0] b);
        if (model_cnt < FIFO_DEPTH) begin
            tx_exp_q.push_back(b);
            model_cnt++;
        end else begin
            model_ovf = 1'b1;
        end
        bus_write(A_TX_DATA, {24'h0, b}, 4'b0001);
    endtask

    task automatic test_reset();
        logic [31:0] got, e;
        repeat (2) @(negedge clk);
        tests_run++;
        if (o_tx_valid !== 1'b0 || o_timer_irq !== 1'b0 || o_tx_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_outputs: valid=%b irq=%b data=%h, need 0 0 00",
                     o_tx_valid, o_timer_irq, o_tx_data);
        end
        rst_n = 1'b1;
        rd_exp_q.push_back(32'h0000_0002);
        bus_read(A_TX_STAT, got);
        e = rd_exp_q.pop_front();
        tests_run++;
        if (got !== e) begin
            tests_failed++;
            $display("FAIL reset_status: got %h need %h", got, e);
        end
        repeat (10) @(negedge clk);
        rd_exp_q.push_back(TIMER_EN ? 32'd10 : 32'd0);
        rd_exp_q.push_back(TIMER_EN ? 32'hFFFF_FFFF : 32'd0);
        bus_read(A_MT_LO, got);
        e = rd_exp_q.pop_front();
        tests_run++;
        if (got !== e) begin
            tests_failed++;
            $display("FAIL mtime_cycle10: got %h need %h", got, e);
        end
        bus_read(A_CMP_HI, got);
        e = rd_exp_q.pop_front();
        tests_run++;
        if (got !== e) begin
            tests_failed++;
            $display("FAIL reset_mtimecmp_hi: got %h need %h", got, e);
        end
    endtask

    task automatic test_ram();
        logic [31:0] got, e;
        logic [29:0] addrs [6];
        @(negedge clk);
        bus_write(30'd5, 32'hDEAD_BEEF, 4'b1111);
        bus_write(30'd5, 32'h0000_00AA, 4'b0001);
        bus_write(30'd9, 32'h1122_3344, 4'b1111);
        bus_write(30'd9, 32'hAABB_CCDD, 4'b1010);
        bus_write(30'h2000_0005, 32'hFFFF_FFFF, 4'b1111);
        bus_write(MMIO | 30'd7, 32'hFFFF_FFFF, 4'b1111);
        addrs[0] = 30'd5;                rd_exp_q.push_back(32'hDEAD_BEAA);
        addrs[1] = 30'd5 + RAM_WORDS;    rd_exp_q.push_back(32'hDEAD_BEAA);
        addrs[2] = 30'd9;                rd_exp_q.push_back(32'hAA22_CC44);
        addrs[3] = 30'h2000_0005;        rd_exp_q.push_back(32'h0);
        addrs[4] = A_TX_DATA;            rd_exp_q.push_back(32'h0);
        addrs[5] = A_TX_STAT;            rd_exp_q.push_back(32'h0000_0002);
        for (int i = 0; i < 6; i++) begin
            bus_read(addrs[i], got);
            e = rd_exp_q.pop_front();
            tests_run++;
            if (got !== e) begin
                tests_failed++;
                $display("FAIL ram_read[%0d] addr %h: got %h need %h", i, addrs[i], got, e);
            end
        end
    endtask

    task automatic test_fifo_overflow();
        logic [31:0] got, e;
        logic [7:0]  eb;
        int cycles;
        @(negedge clk);
        i_tx_ready = 1'b0;
        for (int i = 1; i <= 9; i++) fifo_push(8'(i));
        rd_exp_q.push_back(status_word(model_cnt, model_ovf));
        bus_read(A_TX_STAT, got);
        e = rd_exp_q.pop_front();
        tests_run++;
        if (got !== e) begin
            tests_failed++;
            $display("FAIL ovf_status: got %h need %h", got, e);
        end
        i_tx_ready = 1'b1;
        cycles = 0;
        for (int c = 0; c < 40 && tx_exp_q.size() > 0; c++) begin
            if (o_tx_valid) begin
                eb = tx_exp_q.pop_front();
                model_cnt--;
                tests_run++;
                if (o_tx_data !== eb) begin
                    tests_failed++;
                    $display("FAIL ovf_drain_byte: got %h need %h", o_tx_data, eb);
                end
            end
            cycles++;
            @(negedge clk);
        end
        tests_run++;
        if (tx_exp_q.size() != 0 || cycles != 8 || o_tx_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_drain_end: left=%0d cycles=%0d valid=%b, need 0 8 0",
                     tx_exp_q.size(), cycles, o_tx_valid);
            tx_exp_q.delete();
        end
        i_tx_ready = 1'b0;
        bus_write(A_TX_STAT, 32'h0000_0004, 4'b0001);
        model_ovf = 1'b0;
        model_cnt = 0;
        rd_exp_q.push_back(status_word(model_cnt, model_ovf));
        bus_read(A_TX_STAT, got);
        e = rd_exp_q.pop_front();
        tests_run++;
        if (got !== e) begin
            tests_failed++;
            $display("FAIL ovf_clear: got %h need %h", got, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got, e;
        logic [7:0]  eb;
        int pops;
        @(negedge clk);
        for (int i = 0; i < FIFO_DEPTH; i++) fifo_push(8'h10 + 8'(i));
        // Full FIFO: push 0x55 in the same cycle the head is popped.
        tx_exp_q.push_back(8'h55);
        i_mem_addr = A_TX_DATA;
        i_mem_data = 32'h0000_0055;
        i_mem_mask = 4'b0001;
        i_mem_we   = 1'b1;
        i_tx_ready = 1'b1;
        #1;
        eb = tx_exp_q.pop_front();
        tests_run++;
        if (o_tx_valid !== 1'b1 || o_tx_data !== eb) begin
            tests_failed++;
            $display("FAIL b2b_head: valid=%b data=%h need 1 %h", o_tx_valid, o_tx_data, eb);
        end
        @(negedge clk);
        i_mem_we   = 1'b0;
        i_mem_mask = 4'h0;
        i_tx_ready = 1'b0;
        rd_exp_q.push_back(status_word(FIFO_DEPTH, 1'b0));
        bus_read(A_TX_STAT, got);
        e = rd_exp_q.pop_front();
        tests_run++;
        if (got !== e) begin
            tests_failed++;
            $display("FAIL b2b_status: got %h need %h", got, e);
        end
        @(negedge clk);
        i_tx_ready = 1'b1;
        pops = 0;
        for (int c = 0; c < 40 && tx_exp_q.size() > 0; c++) begin
            if (o_tx_valid) begin
                eb = tx_exp_q.pop_front();
                pops++;
                tests_run++;
                if (o_tx_data !== eb) begin
                    tests_failed++;
                    $display("FAIL b2b_drain_byte: got %h need %h", o_tx_data, eb);
                end
            end
            @(negedge clk);
        end
        tests_run++;
        if (tx_exp_q.size() != 0 || pops != FIFO_DEPTH || o_tx_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_drain_end: left=%0d pops=%0d valid=%b, need 0 %0d 0",
                     tx_exp_q.size(), pops, o_tx_valid, FIFO_DEPTH);
            tx_exp_q.delete();
        end
        i_tx_ready = 1'b0;
        model_cnt = 0;
    endtask

    task automatic test_timer();
        logic [31:0] got, e;
        bit          irq_exp;
        @(negedge clk);
`ifdef DATA_BUS_TIMER_EN
        bus_write(A_MT_HI, 32'h0, 4'hF);
        bus_write(A_MT_LO, 32'h0, 4'hF);
        bus_write(A_CMP_HI, 32'h0, 4'hF);
        bus_write(A_CMP_LO, 32'd100, 4'hF);
        bus_write(A_MT_LO, 32'd95, 4'hF);
        for (int k = 0; k < 9; k++) begin
            rd_exp_q.push_back(32'd95 + 32'(k));
            irq_exp = (k >= 6);
            bus_read(A_MT_LO, got);
            e = rd_exp_q.pop_front();
            tests_run++;
            if (got !== e || o_timer_irq !== irq_exp) begin
                tests_failed++;
                $display("FAIL irq_rise k=%0d: mtime %0d irq %b need %0d %b",
                         k, got, o_timer_irq, e, irq_exp);
            end
            @(negedge clk);
        end
        bus_write(A_CMP_HI, 32'd1, 4'hF);
        tests_run++;
        if (o_timer_irq !== 1'b1) begin
            tests_failed++;
            $display("FAIL irq_hold: got %b need 1", o_timer_irq);
        end
        @(negedge clk);
        tests_run++;
        if (o_timer_irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL irq_fall: got %b need 0", o_timer_irq);
        end
        // 64-bit wrap, with byte-masked writes building the value.
        bus_write(A_MT_HI, 32'hFFFF_FFFF, 4'hF);
        bus_write(A_MT_LO, 32'hFFFF_0000, 4'b1100);
        bus_write(A_MT_LO, 32'h0000_FFFE, 4'b0011);
        rd_exp_q.push_back(32'hFFFF_FFFE);
        bus_read(A_MT_LO, got);
        e = rd_exp_q.pop_front();
        tests_run++;
        if (got !== e) begin
            tests_failed++;
            $display("FAIL mtime_masked_write: got %h need %h", got, e);
        end
        repeat (2) @(negedge clk);
        rd_exp_q.push_back(32'h0);
        rd_exp_q.push_back(32'h0);
        bus_read(A_MT_LO, got);
        e = rd_exp_q.pop_front();
        tests_run++;
        if (got !== e) begin
            tests_failed++;
            $display("FAIL mtime_wrap_lo: got %h need %h", got, e);
        end
        bus_read(A_MT_HI, got);
        e = rd_exp_q.pop_front();
        tests_run++;
        if (got !== e) begin
            tests_failed++;
            $display("FAIL mtime_wrap_hi: got %h need %h", got, e);
        end
`else
        bus_write(A_MT_LO, 32'h1234_5678, 4'hF);
        bus_write(A_CMP_LO, 32'h0, 4'hF);
        bus_write(A_CMP_HI, 32'h0, 4'hF);
        repeat (3) @(negedge clk);
        rd_exp_q.push_back(32'h0);
        rd_exp_q.push_back(32'h0);
        bus_read(A_MT_LO, got);
        e = rd_exp_q.pop_front();
        irq_exp = 1'b0;
        tests_run++;
        if (got !== e || o_timer_irq !== irq_exp) begin
            tests_failed++;
            $display("FAIL timer_off_mtime: got %h irq %b need %h %b", got, o_timer_irq, e, irq_exp);
        end
        bus_read(A_CMP_LO, got);
        e = rd_exp_q.pop_front();
        tests_run++;
        if (got !== e) begin
            tests_failed++;
            $display("FAIL timer_off_cmp: got %h need %h", got, e);
        end
`endif
    endtask

    task automatic test_reset_midop();
        logic [31:0] got, e;
        @(negedge clk);
        i_tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) fifo_push(8'hA0 + 8'(i));
        bus_write(A_CMP_HI, 32'h0, 4'hF);
        bus_write(A_CMP_LO, 32'h0, 4'hF);
        @(negedge clk);
        tests_run++;
        if (o_tx_valid !== 1'b1 || o_tx_data !== tx_exp_q[0] || o_timer_irq !== TIMER_EN) begin
            tests_failed++;
            $display("FAIL midop_pre: valid=%b data=%h irq=%b need 1 %h %b",
                     o_tx_valid, o_tx_data, o_timer_irq, tx_exp_q[0], TIMER_EN);
        end
        #2;
        rst_n = 1'b0;
        tx_exp_q.delete();
        model_cnt = 0;
        model_ovf = 1'b0;
        #1;
        tests_run++;
        if (o_tx_valid !== 1'b0 || o_timer_irq !== 1'b0 || o_tx_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL midop_async: valid=%b irq=%b data=%h need 0 0 00",
                     o_tx_valid, o_timer_irq, o_tx_data);
        end
        rd_exp_q.push_back(status_word(0, 1'b0));
        bus_read(A_TX_STAT, got);
        e = rd_exp_q.pop_front();
        tests_run++;
        if (got !== e) begin
            tests_failed++;
            $display("FAIL midop_status: got %h need %h", got, e);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rd_exp_q.push_back(32'hDEAD_BEAA);
        rd_exp_q.push_back(32'hAA22_CC44);
        rd_exp_q.push_back(TIMER_EN ? 32'hFFFF_FFFF : 32'h0);
        bus_read(30'd5, got);
        e = rd_exp_q.pop_front();
        tests_run++;
        if (got !== e) begin
            tests_failed++;
            $display("FAIL midop_ram5: got %h need %h", got, e);
        end
        bus_read(30'd9, got);
        e = rd_exp_q.pop_front();
        tests_run++;
        if (got !== e) begin
            tests_failed++;
            $display("FAIL midop_ram9: got %h need %h", got, e);
        end
        bus_read(A_CMP_LO, got);
        e = rd_exp_q.pop_front();
        tests_run++;
        if (got !== e) begin
            tests_failed++;
            $display("FAIL midop_cmp_lo: got %h need %h", got, e);
        end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_fifo_overflow();
        test_back_to_back();
        test_timer();
        test_reset_midop();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
